// File: rtl/uart_pkg.sv
// Shared constants, state encoding and width helper for the UART frame controller.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_WID = 8;
  localparam logic [UART_DATA_WID-1:0] SYNC_BYTE = 8'hA5;
  localparam int PAYLOAD_NUM = 80;
  localparam int WORK_WID = PAYLOAD_NUM * UART_DATA_WID;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } frame_state_e;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte stream from the UART receiver plus the work-item handshake to the scheduler.
// Latency: n/a (wiring only).
// Backpressure: work side is valid/ready; the byte side is a strobe with no backpressure.
interface uart_rx_frame_ctrl_if;
  import uart_pkg::*;

  logic [UART_DATA_WID-1:0] iv_rx_data;
  logic                     i_rx_data_vld;
  logic [WORK_WID-1:0]      ov_work_data;
  logic                     o_work_vld;
  logic                     i_work_rdy;

  // Host side: receiver feeding bytes, scheduler consuming work items.
  modport master (
    output iv_rx_data,
    output i_rx_data_vld,
    output i_work_rdy,
    input  ov_work_data,
    input  o_work_vld
  );

  // Frame controller side.
  modport slave (
    input  iv_rx_data,
    input  i_rx_data_vld,
    input  i_work_rdy,
    output ov_work_data,
    output o_work_vld
  );

endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: counts enabled cycles, clears on i_clr, pulses o_expire.
// Latency: o_expire is combinational in the cycle the count sits at TIMEOUT-1.
// Backpressure: none; a clear in the expiry cycle suppresses the pulse.
module uart_frame_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int TMR_W = log2(TIMEOUT);

  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;

  // A byte arriving in the same cycle wins over expiry.
  assign o_expire = i_en & ~i_clr & (tmr_q == TMR_W'(TIMEOUT - 1));

  // Next count: clear on byte/idle or on expiry, otherwise count while enabled.
  always_comb begin
    tmr_d = tmr_q;
    if (i_clr || o_expire) begin
      tmr_d = '0;
    end else if (i_en) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sync hunt, 80-byte header assembly, XOR checksum and timeout supervision; emits work items.
// Latency: o_work_vld / o_frame_err rise one cycle after the checksum byte strobe (or timeout).
// Backpressure: work item held until accepted; a frame completing while the output is full is dropped.
module uart_rx_frame_ctrl
  import uart_pkg::frame_state_e, uart_pkg::IDLE, uart_pkg::PAYLOAD, uart_pkg::CHECK,
         uart_pkg::ERR_CSUM, uart_pkg::ERR_TMO, uart_pkg::ERR_OVF, uart_pkg::log2;
#(
  parameter string IS_SIM      = "TRUE",
  parameter int    TIMEOUT_CNT = 1000000,
  parameter int    TIMEOUT_SIM = 200,
  parameter int    UART_DATA_WID = uart_pkg::UART_DATA_WID,
  parameter logic [UART_DATA_WID-1:0] SYNC_BYTE = uart_pkg::SYNC_BYTE,
  parameter int    PAYLOAD_NUM = uart_pkg::PAYLOAD_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_ctrl_if.slave   bus,
  output logic                  o_frame_err,
  output logic [1:0]            ov_err_code,
  output logic [15:0]           ov_frame_cnt,
  output logic                  o_busy
);

  localparam int TMO_CYCLES = (IS_SIM == "TRUE") ? TIMEOUT_SIM : TIMEOUT_CNT;
  localparam int CNT_W      = log2(PAYLOAD_NUM);
  localparam int WORK_W     = PAYLOAD_NUM * UART_DATA_WID;

  frame_state_e state_q, state_d;

  logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic [UART_DATA_WID-1:0] csum_q, csum_d;
  logic [WORK_W-1:0]        shift_q, shift_d;
  logic [WORK_W-1:0]        work_data_q, work_data_d;
  logic                     work_vld_q, work_vld_d;
  logic                     frame_err_q, frame_err_d;
  logic [1:0]               err_code_q, err_code_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     busy_q, busy_d;

  logic                     rx_vld;
  logic [UART_DATA_WID-1:0] rx_data;
  logic                     out_free;
  logic                     tmr_clr;
  logic                     tmr_en;
  logic                     tmr_expire;

  assign rx_vld  = bus.i_rx_data_vld;
  assign rx_data = bus.iv_rx_data;

  // Output slot can take a new item if empty or being drained this very cycle.
  assign out_free = ~work_vld_q | bus.i_work_rdy;

  // Timer only runs inside a frame and restarts on every byte.
  assign tmr_clr = rx_vld | (state_q == IDLE);
  assign tmr_en  = (state_q != IDLE);

  uart_frame_timer #(
    .TIMEOUT (TMO_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (tmr_clr),
    .i_en     (tmr_en),
    .o_expire (tmr_expire)
  );

  // Frame FSM next-state, shifter, checksum and output register update.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    csum_d      = csum_q;
    shift_d     = shift_q;
    work_data_d = work_data_q;
    work_vld_d  = work_vld_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;

    if (work_vld_q && bus.i_work_rdy) begin
      work_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_vld && (rx_data == SYNC_BYTE)) begin
          state_d    = PAYLOAD;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end

      PAYLOAD: begin
        if (rx_vld) begin
          shift_d    = {shift_q[WORK_W-UART_DATA_WID-1:0], rx_data};
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == CNT_W'(PAYLOAD_NUM - 1)) begin
            state_d = CHECK;
          end
        end else if (tmr_expire) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
        end
      end

      CHECK: begin
        if (rx_vld) begin
          state_d = IDLE;
          if (rx_data == csum_q) begin
            if (out_free) begin
              work_data_d = shift_q;
              work_vld_d  = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_OVF;
            end
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end else if (tmr_expire) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; all cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      csum_q      <= '0;
      shift_q     <= '0;
      work_data_q <= '0;
      work_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      frame_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      csum_q      <= csum_d;
      shift_q     <= shift_d;
      work_data_q <= work_data_d;
      work_vld_q  <= work_vld_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ov_work_data = work_data_q;
  assign bus.o_work_vld   = work_vld_q;
  assign o_frame_err      = frame_err_q;
  assign ov_err_code      = err_code_q;
  assign ov_frame_cnt     = frame_cnt_q;
  assign o_busy           = busy_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Frame controller sitting directly behind the UART receiver in the miner's host link.
- Consumes the receiver's byte stream (data, one-cycle valid strobe) and hunts for a sync byte.
- Assembles an 80-byte block header, checks an XOR checksum and supervises inter-byte timeout.
- Presents the complete 640-bit work item to the hashing scheduler through a valid/ready handshake, and reports errors and a good-frame count.

Parameters:
- IS_SIM, "TRUE", "TRUE" selects TIMEOUT_SIM; "FALSE" selects TIMEOUT_CNT
- TIMEOUT_CNT, 1000000, inter-byte timeout in clk cycles (10 ms at 100 MHz)
- TIMEOUT_SIM, 200, inter-byte timeout in clk cycles for simulation
- SYNC_BYTE, 8'hA5, frame start marker
- PAYLOAD_NUM, 80, payload bytes per frame (frame = 1 sync + PAYLOAD_NUM + 1 checksum = 82)
- UART_DATA_WID, 8, byte width

Ports:
- clk  in  1  block clock
- rst  in  1  reset; asynchronous assert, active-low
- iv_rx_data  in  8  received byte; sampled only when i_rx_data_vld=1
- i_rx_data_vld  in  1  one-cycle byte strobe from the receiver
- ov_work_data  out  640  assembled payload; first payload byte in [639:632]
- o_work_vld  out  1  work item valid; held until accepted
- i_work_rdy  in  1  downstream accepts when o_work_vld & i_work_rdy
- o_frame_err  out  1  one-cycle error pulse
- ov_err_code  out  2  01 checksum, 10 timeout, 11 overflow; holds last code
- ov_frame_cnt  out  16  good frames delivered; wraps at 16'hFFFF -> 0
- o_busy  out  1  high while state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters 0, ov_work_data=0, o_work_vld=0, o_frame_err=0, ov_err_code=0, ov_frame_cnt=0, o_busy=0.
- State machine:
  - IDLE: a vld byte equal to SYNC_BYTE -> PAYLOAD, with byte_cnt=0, csum=0, timer=0. Any other byte is discarded silently and no error is raised.
  - PAYLOAD: each vld byte shifts in (shift_reg <= {shift_reg[631:0], byte}), csum ^= byte, byte_cnt++. On the vld with byte_cnt==PAYLOAD_NUM-1 -> CHECK.
  - CHECK: on vld, compare the byte with csum, then -> IDLE.
    - Equal and output free: load ov_work_data, set o_work_vld, ov_frame_cnt++.
    - Equal and output not free: drop the frame, overflow error.
    - Unequal: checksum error; ov_work_data and o_work_vld are unchanged.
- Output free condition: o_work_vld==0, or o_work_vld & i_work_rdy in the same cycle. Accept and load in one cycle is legal and is not an overflow.
- Latency: o_work_vld rises the cycle after the checksum byte's vld. o_frame_err pulses the cycle after the offending event.
- Handshake:
  - o_work_vld stays high and ov_work_data stays stable until o_work_vld & i_work_rdy.
  - o_work_vld deasserts the next cycle unless a new frame loads in that same cycle.
- Timeout:
  - In PAYLOAD or CHECK, the timer increments every cycle without vld and clears on vld.
  - When timer reaches the selected timeout minus 1: -> IDLE, timeout error, partial frame discarded.
  - If vld and the timeout coincide, vld wins and the timer clears.
  - No timer runs in IDLE.
- A byte equal to SYNC_BYTE inside PAYLOAD is payload data. It never resynchronises the frame.
- The shift register is internal; ov_work_data is a separate output register, so a partial frame never disturbs the presented work item.
- Widths: byte_cnt = log2(PAYLOAD_NUM) bits. The timer width comes from log2 of the selected timeout.
- Error pulse and the ov_err_code update occur together.

Decomposition:
- Shared package (uart_pkg):
  - SYNC_BYTE, PAYLOAD_NUM and the error code constants (ERR_CSUM=2'b01, ERR_TMO=2'b10, ERR_OVF=2'b11)
  - state encoding (IDLE, PAYLOAD, CHECK)
  - the log2 function
- One natural sub-module, uart_frame_timer: the inter-byte timeout counter with clear/enable inputs and an expiry pulse.
- FSM, shifter, checksum and output register live in the top module.

Test Plan:
- Good frame: A5, payload 00..4F, checksum 0x00 (XOR of 00..4F), i_work_rdy=1 -> o_work_vld one cycle after the last strobe; ov_work_data[639:632]=00, [7:0]=4F; ov_frame_cnt=1; no error.
- Bad checksum: same frame with last byte 0x01 -> o_frame_err pulse, ov_err_code=01, o_work_vld stays 0, ov_frame_cnt=0.
- Garbage then sync: bytes 12, 34, then a good frame -> no error, frame delivered intact.
- Timeout (IS_SIM="TRUE"): A5 + 10 payload bytes, then silence for 200 cycles -> o_frame_err with code 10, o_busy=0; a following good frame is delivered correctly.
- Overflow and simultaneous accept, with i_work_rdy=0:
  - Two good frames -> second raises code 11; first frame data is unchanged.
  - Repeat with i_work_rdy=1 exactly on the second frame's completion cycle -> no error; second frame loads; ov_frame_cnt increments twice.
- Reset mid-frame: rst low after 40 payload bytes -> all outputs return to reset values immediately; after release, a good frame is delivered with ov_frame_cnt=1.
